// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit for the 32-bit single-bus datapath
module control_sequencer #(
    parameter int             OPW     = 5,
    parameter logic [OPW-1:0] ALU_ADD = 5'b00011
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           con_ff_bit,
    output logic           IRin,
    output logic           PCin,
    output logic           RYin,
    output logic           RZin,
    output logic           MARin,
    output logic           MDRin,
    output logic           HIin,
    output logic           LOin,
    output logic           Outport_in,
    output logic           HIout,
    output logic           LOout,
    output logic           Zhi_out,
    output logic           Zlo_out,
    output logic           PCout,
    output logic           MDRout,
    output logic           Inport_out,
    output logic           Cout,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           CONin,
    output logic           Mem_read,
    output logic           Mem_write,
    output logic           IncPC,
    output logic [OPW-1:0] opcode,
    output logic           run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'('h00);
    localparam logic [OPW-1:0] OP_LDI  = OPW'('h01);
    localparam logic [OPW-1:0] OP_ST   = OPW'('h02);
    localparam logic [OPW-1:0] OP_ADD  = OPW'('h03);
    localparam logic [OPW-1:0] OP_ROL  = OPW'('h0B);
    localparam logic [OPW-1:0] OP_ADDI = OPW'('h0C);
    localparam logic [OPW-1:0] OP_ORI  = OPW'('h0E);
    localparam logic [OPW-1:0] OP_MUL  = OPW'('h0F);
    localparam logic [OPW-1:0] OP_DIV  = OPW'('h10);
    localparam logic [OPW-1:0] OP_NEG  = OPW'('h11);
    localparam logic [OPW-1:0] OP_NOT  = OPW'('h12);
    localparam logic [OPW-1:0] OP_BR   = OPW'('h13);
    localparam logic [OPW-1:0] OP_JR   = OPW'('h14);
    localparam logic [OPW-1:0] OP_IN   = OPW'('h16);
    localparam logic [OPW-1:0] OP_OUT  = OPW'('h17);
    localparam logic [OPW-1:0] OP_MFHI = OPW'('h18);
    localparam logic [OPW-1:0] OP_MFLO = OPW'('h19);
    localparam logic [OPW-1:0] OP_HALT = OPW'('h1B);

    state_t         r_state;
    state_t         w_next_state;
    logic [OPW-1:0] w_op;
    logic           w_is_ld, w_is_ldi, w_is_st, w_is_mem;
    logic           w_is_rtype, w_is_imm, w_is_muldiv, w_is_negnot, w_is_br, w_is_halt;
    logic           w_addr_step;
    logic [2:0]     w_last_step;
    logic           w_unused_ir;

    assign w_op        = ir[31:32-OPW];
    assign w_unused_ir = ^ir[31-OPW:0];

    assign w_is_ld     = (w_op == OP_LD);
    assign w_is_ldi    = (w_op == OP_LDI);
    assign w_is_st     = (w_op == OP_ST);
    assign w_is_mem    = w_is_ld | w_is_ldi | w_is_st;
    assign w_is_rtype  = (w_op >= OP_ADD) && (w_op <= OP_ROL);
    assign w_is_imm    = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
    assign w_is_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
    assign w_is_negnot = (w_op == OP_NEG) || (w_op == OP_NOT);
    assign w_is_br     = (w_op == OP_BR);
    assign w_is_halt   = (w_op == OP_HALT);

    // Steps where the ALU must add regardless of the instruction's own opcode
    assign w_addr_step = (w_is_mem && (r_state == S_T3 || r_state == S_T4)) ||
                         (w_is_br  && (r_state == S_T4 || r_state == S_T5));

    always_comb begin
        w_last_step = 3'd3;
        if (w_is_ld || w_is_st)                      w_last_step = 3'd7;
        else if (w_is_ldi || w_is_rtype || w_is_imm) w_last_step = 3'd5;
        else if (w_is_muldiv || w_is_br)             w_last_step = 3'd6;
        else if (w_is_negnot)                        w_last_step = 3'd4;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= S_RST;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RST:  w_next_state = S_T0;
            S_T0:   w_next_state = S_T1;
            S_T1:   w_next_state = S_T2;
            S_T2:   w_next_state = S_T3;
            S_T3:   w_next_state = w_is_halt ? S_HALT : ((w_last_step == 3'd3) ? S_T0 : S_T4);
            S_T4:   w_next_state = (w_last_step == 3'd4) ? S_T0 : S_T5;
            S_T5:   w_next_state = (w_last_step == 3'd5) ? S_T0 : S_T6;
            S_T6:   w_next_state = (w_last_step == 3'd6) ? S_T0 : S_T7;
            S_T7:   w_next_state = S_T0;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_RST;
        endcase
    end

    always_comb begin
        IRin = 1'b0; PCin = 1'b0; RYin = 1'b0; RZin = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; HIin = 1'b0; LOin = 1'b0; Outport_in = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Zhi_out = 1'b0; Zlo_out = 1'b0; PCout = 1'b0;
        MDRout = 1'b0; Inport_out = 1'b0; Cout = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; CONin = 1'b0;
        Mem_read = 1'b0; Mem_write = 1'b0; IncPC = 1'b0;
        opcode = '0;
        run = 1'b0;
        case (r_state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
            end
            S_T1: begin
                Zlo_out = 1'b1; PCin = 1'b1; Mem_read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (w_is_mem) begin
                    Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; RYin = 1'b1;
                end else if (w_is_rtype || w_is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; RYin = 1'b1;
                end else if (w_is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; RYin = 1'b1;
                end else if (w_is_negnot) begin
                    Grb = 1'b1; Rout = 1'b1; RZin = 1'b1;
                end else if (w_is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else begin
                    case (w_op)
                        OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OP_IN:   begin Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; Outport_in = 1'b1; end
                        OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                if (w_is_mem || w_is_imm) begin
                    Cout = 1'b1; RZin = 1'b1;
                end else if (w_is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; RZin = 1'b1;
                end else if (w_is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; RZin = 1'b1;
                end else if (w_is_negnot) begin
                    Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_is_br) begin
                    PCout = 1'b1; RYin = 1'b1;
                end
            end
            S_T5: begin
                if (w_is_ldi || w_is_rtype || w_is_imm) begin
                    Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_is_ld || w_is_st) begin
                    Zlo_out = 1'b1; MARin = 1'b1;
                end else if (w_is_muldiv) begin
                    Zlo_out = 1'b1; LOin = 1'b1;
                end else if (w_is_br) begin
                    Cout = 1'b1; RZin = 1'b1;
                end
            end
            S_T6: begin
                if (w_is_ld) begin
                    Mem_read = 1'b1; MDRin = 1'b1;
                end else if (w_is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (w_is_muldiv) begin
                    Zhi_out = 1'b1; HIin = 1'b1;
                end else if (w_is_br && con_ff_bit) begin
                    Zlo_out = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                if (w_is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_is_st) begin
                    Mem_write = 1'b1;
                end
            end
            default: ;
        endcase
        if (r_state != S_RST && r_state != S_HALT) run = 1'b1;
        if (r_state == S_T0 || w_addr_step)
            opcode = ALU_ADD;
        else if (r_state == S_T3 || r_state == S_T4 || r_state == S_T5 ||
                 r_state == S_T6 || r_state == S_T7)
            opcode = w_op;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed and random microstep checks for control_sequencer
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = '0;
    logic        con_ff_bit = 1'b0;
    logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in;
    logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CONin, Mem_read, Mem_write, IncPC;
    logic [4:0] opcode;
    logic       run;

    int n_cmp  = 0;
    int n_fail = 0;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff_bit(con_ff_bit),
        .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
        .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .Outport_in(Outport_in),
        .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .CONin(CONin), .Mem_read(Mem_read), .Mem_write(Mem_write), .IncPC(IncPC),
        .opcode(opcode), .run(run)
    );

    always #5 clock = ~clock;

    localparam logic [4:0]  ADD     = 5'b00011;
    localparam logic [26:0] IRIN    = 27'd1 << 0;
    localparam logic [26:0] PCIN    = 27'd1 << 1;
    localparam logic [26:0] RYIN    = 27'd1 << 2;
    localparam logic [26:0] RZIN    = 27'd1 << 3;
    localparam logic [26:0] MARIN   = 27'd1 << 4;
    localparam logic [26:0] MDRIN   = 27'd1 << 5;
    localparam logic [26:0] HIIN    = 27'd1 << 6;
    localparam logic [26:0] LOIN    = 27'd1 << 7;
    localparam logic [26:0] OUTPIN  = 27'd1 << 8;
    localparam logic [26:0] HIOUT   = 27'd1 << 9;
    localparam logic [26:0] LOOUT   = 27'd1 << 10;
    localparam logic [26:0] ZHI     = 27'd1 << 11;
    localparam logic [26:0] ZLO     = 27'd1 << 12;
    localparam logic [26:0] PCOUT   = 27'd1 << 13;
    localparam logic [26:0] MDROUT  = 27'd1 << 14;
    localparam logic [26:0] INPOUT  = 27'd1 << 15;
    localparam logic [26:0] COUT    = 27'd1 << 16;
    localparam logic [26:0] GRA     = 27'd1 << 17;
    localparam logic [26:0] GRB     = 27'd1 << 18;
    localparam logic [26:0] GRC     = 27'd1 << 19;
    localparam logic [26:0] RIN     = 27'd1 << 20;
    localparam logic [26:0] ROUT    = 27'd1 << 21;
    localparam logic [26:0] BAOUT   = 27'd1 << 22;
    localparam logic [26:0] CONIN   = 27'd1 << 23;
    localparam logic [26:0] MRD     = 27'd1 << 24;
    localparam logic [26:0] MWR     = 27'd1 << 25;
    localparam logic [26:0] INCPC   = 27'd1 << 26;

    logic [32:0] exp_q[$];

    function automatic logic [32:0] obs_word();
        return {run, opcode, IncPC, Mem_write, Mem_read, CONin, BAout, Rout, Rin,
                Grc, Grb, Gra, Cout, Inport_out, MDRout, PCout, Zlo_out, Zhi_out,
                LOout, HIout, Outport_in, LOin, HIin, MDRin, MARin, RZin, RYin,
                PCin, IRin};
    endfunction

    function automatic void step(logic [26:0] m, logic [4:0] opc);
        exp_q.push_back({1'b1, opc, m});
    endfunction

    // Microprogram of one whole instruction, fetch included
    function automatic void build(logic [4:0] op, logic con);
        int o = int'(op);
        exp_q.delete();
        step(PCOUT | MARIN | INCPC | RZIN, ADD);
        step(ZLO | PCIN | MRD | MDRIN, 5'd0);
        step(MDROUT | IRIN, 5'd0);
        if (o <= 2) begin
            step(GRB | ROUT | BAOUT | RYIN, ADD);
            step(COUT | RZIN, ADD);
            if (o == 1) step(ZLO | GRA | RIN, op);
            else begin
                step(ZLO | MARIN, op);
                step((o == 0) ? (MRD | MDRIN) : (GRA | ROUT | MDRIN), op);
                step((o == 0) ? (MDROUT | GRA | RIN) : MWR, op);
            end
        end else if (o <= 'h0E) begin
            step(GRB | ROUT | RYIN, op);
            step((o <= 'h0B) ? (GRC | ROUT | RZIN) : (COUT | RZIN), op);
            step(ZLO | GRA | RIN, op);
        end else if (o <= 'h10) begin
            step(GRA | ROUT | RYIN, op);
            step(GRB | ROUT | RZIN, op);
            step(ZLO | LOIN, op);
            step(ZHI | HIIN, op);
        end else if (o <= 'h12) begin
            step(GRB | ROUT | RZIN, op);
            step(ZLO | GRA | RIN, op);
        end else if (o == 'h13) begin
            step(GRA | ROUT | CONIN, op);
            step(PCOUT | RYIN, ADD);
            step(COUT | RZIN, ADD);
            step(con ? (ZLO | PCIN) : 27'd0, op);
        end else if (o == 'h14) step(GRA | ROUT | PCIN, op);
        else if (o == 'h16) step(INPOUT | GRA | RIN, op);
        else if (o == 'h17) step(GRA | ROUT | OUTPIN, op);
        else if (o == 'h18) step(HIOUT | GRA | RIN, op);
        else if (o == 'h19) step(LOOUT | GRA | RIN, op);
        else step(27'd0, op);
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered right after a falling edge with the sequencer in T0
    task automatic run_instr(input string tag, input logic [31:0] v, input logic con,
                             input int nsteps);
        int n;
        ir = v;
        con_ff_bit = con;
        build(v[31:27], con);
        n = (nsteps < 0) ? exp_q.size() : nsteps;
        for (int i = 0; i < n; i++) begin
            #1 check($sformatf("%s_t%0d", tag, i), obs_word(), exp_q[i]);
            @(negedge clock);
        end
    endtask

    task automatic do_reset(input string tag);
        clear = 1'b0;
        #1 check({tag, "_async"}, obs_word(), 33'd0);
        @(negedge clock);
        clear = 1'b1;
        #1 check({tag, "_rst"}, obs_word(), 33'd0);
        @(negedge clock);
    endtask

    initial begin
        logic [4:0] op;
        #2;
        do_reset("reset");

        run_instr("add",   32'h18918000, 1'b0, -1);
        run_instr("ld",    32'h00800010, 1'b0, -1);
        run_instr("ldi",   32'h08800010, 1'b1, -1);
        run_instr("st",    32'h10800010, 1'b0, -1);
        run_instr("br1",   32'h98800004, 1'b1, -1);
        run_instr("br0",   32'h98800004, 1'b0, -1);
        run_instr("addi",  32'h60912345, 1'b0, -1);
        run_instr("mul",   32'h79100000, 1'b0, -1);
        run_instr("div",   32'h81100000, 1'b1, -1);
        run_instr("neg",   32'h88900000, 1'b0, -1);
        run_instr("not",   32'h90900000, 1'b0, -1);
        run_instr("jr",    32'hA0800000, 1'b0, -1);
        run_instr("in",    32'hB0800000, 1'b0, -1);
        run_instr("out",   32'hB8800000, 1'b0, -1);
        run_instr("mfhi",  32'hC0800000, 1'b0, -1);
        run_instr("mflo",  32'hC8800000, 1'b0, -1);
        run_instr("nop",   32'hD0000000, 1'b0, -1);
        run_instr("und1f", 32'hF8000000, 1'b1, -1);
        run_instr("und15", 32'hA8000000, 1'b0, -1);

        // Abort an add in T4
        run_instr("addab", 32'h18918000, 1'b0, 4);
        #1 check("addab_t4", obs_word(), exp_q[4]);
        #2;
        do_reset("midreset");
        run_instr("after_rst", 32'h18918000, 1'b0, -1);

        run_instr("halt", 32'hD8000000, 1'b0, -1);
        for (int i = 0; i < 20; i++) begin
            #1 check($sformatf("halt_idle%0d", i), obs_word(), 33'd0);
            @(negedge clock);
        end
        do_reset("halt_exit");

        for (int k = 0; k < 200; k++) begin
            op = 5'($urandom_range(0, 31));
            run_instr($sformatf("rnd%0d_op%02h", k, op), {op, 27'($urandom)},
                      1'($urandom_range(0, 1)), -1);
            if (op == 5'h1B) begin
                for (int i = 0; i < 3; i++) begin
                    #1 check($sformatf("rnd%0d_halt%0d", k, i), obs_word(), 33'd0);
                    @(negedge clock);
                end
                do_reset($sformatf("rnd%0d_reset", k));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
